health_alarm_priority_ctrl: RTL and testbench

//  Parametrised successor to the single-cycle abnormality-to-warning FSM.

---
 rtl/health_alarm_priority_ctrl_if.sv | 23 ++
 rtl/health_alarm_priority_ctrl.sv | 112 +++++++++++
 tb/tb_health_alarm_priority_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/health_alarm_priority_ctrl_if.sv
// Sensor-side abnormality lines and caregiver ack in, warning code/pending/event count out.
interface health_alarm_priority_ctrl_if #(
    parameter int NUM_SOURCES = 6,
    parameter int EVT_W       = 8
);
    localparam int CODE_W = $clog2(NUM_SOURCES + 1);

    logic [NUM_SOURCES-1:0] abnormality;
    logic                   ack;
    logic [CODE_W-1:0]      abnormalityWarning;
    logic                   alarmPending;
    logic [EVT_W-1:0]       eventCount;

    modport master (
        output abnormality, ack,
        input  abnormalityWarning, alarmPending, eventCount
    );

    modport slave (
        input  abnormality, ack,
        output abnormalityWarning, alarmPending, eventCount
    );
endinterface

// File: rtl/health_alarm_priority_ctrl.sv
// Debounced, priority-ordered sticky warning: confirm each line, show the highest, hold until ack.
// Latency CONFIRM_CYCLES+1 edges from first high sample to warning; no backpressure, all outputs registered.
module health_alarm_priority_ctrl #(
    parameter int NUM_SOURCES    = 6,
    parameter int CONFIRM_CYCLES = 3,
    parameter int HOLD_CYCLES    = 8,
    parameter int EVT_W          = 8
) (
    input  logic                        clock,
    input  logic                        reset,
    health_alarm_priority_ctrl_if.slave bus
);
    localparam int CODE_W = $clog2(NUM_SOURCES + 1);
    localparam int CNT_W  = $clog2(CONFIRM_CYCLES + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(CONFIRM_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q [NUM_SOURCES];
    logic [CNT_W-1:0]   cnt_d [NUM_SOURCES];
    logic [CODE_W-1:0]  warn_q, warn_d;
    logic [CODE_W-1:0]  cand;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [EVT_W-1:0]   evt_q, evt_d;
    logic               evt_inc;

    // Per-source persistence counters; any low sample restarts confirmation.
    always_comb begin
        for (int i = 0; i < NUM_SOURCES; i++) begin
            cnt_d[i] = '0;
            if (bus.abnormality[i]) begin
                cnt_d[i] = (cnt_q[i] == CNT_MAX) ? cnt_q[i] : cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_comb begin
        cand = '0;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            if (cnt_q[i] == CNT_MAX) begin
                cand = CODE_W'(i + 1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        warn_d  = warn_q;
        hold_d  = hold_q;
        evt_inc = 1'b0;
        case (state_q)
            IDLE: begin
                if (cand != '0) begin
                    state_d = ACTIVE;
                    warn_d  = cand;
                    hold_d  = HOLD_LOAD;
                    evt_inc = 1'b1;
                end
            end
            ACTIVE: begin
                // Pre-emption outranks both the hold window and a concurrent ack.
                if (cand > warn_q) begin
                    warn_d  = cand;
                    hold_d  = HOLD_LOAD;
                    evt_inc = 1'b1;
                end else if (hold_q != '0) begin
                    hold_d = hold_q - HOLD_W'(1);
                end else if (bus.ack) begin
                    if (cand == '0) begin
                        state_d = IDLE;
                        warn_d  = '0;
                    end else begin
                        warn_d = cand;
                        hold_d = HOLD_LOAD;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                warn_d  = '0;
            end
        endcase
        evt_d = (evt_inc && (evt_q != '1)) ? evt_q + EVT_W'(1) : evt_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            warn_q  <= '0;
            hold_q  <= '0;
            evt_q   <= '0;
            for (int i = 0; i < NUM_SOURCES; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            warn_q  <= warn_d;
            hold_q  <= hold_d;
            evt_q   <= evt_d;
            for (int i = 0; i < NUM_SOURCES; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign bus.abnormalityWarning = warn_q;
    assign bus.alarmPending       = (state_q == ACTIVE);
    assign bus.eventCount         = evt_q;
endmodule

// File: tb/tb_health_alarm_priority_ctrl.sv
// Directed bench for health_alarm_priority_ctrl with a per-cycle reference model and literal spot checks.
module tb_health_alarm_priority_ctrl;
    localparam int NS    = 6;
    localparam int CONF  = 3;
    localparam int HOLD  = 8;
    localparam int EW    = 8;
    localparam int EVMAX = (1 << EW) - 1;

    logic clock;
    logic reset;

    health_alarm_priority_ctrl_if #(.NUM_SOURCES(NS), .EVT_W(EW)) bus ();

    health_alarm_priority_ctrl #(
        .NUM_SOURCES(NS), .CONFIRM_CYCLES(CONF), .HOLD_CYCLES(HOLD), .EVT_W(EW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference model: run lengths of consecutive high samples, and the age of the
    // currently displayed code in edges since it was (re)loaded.
    int  run_len [NS];
    int  m_warn;
    int  m_age;
    int  m_evt;
    bit  m_pend;
    bit  model_ok = 1'b0;

    always @(posedge clock) begin
        int cand;
        cand = 0;
        for (int i = 0; i < NS; i++) if (run_len[i] >= CONF) cand = i + 1;
        if (reset) begin
            for (int i = 0; i < NS; i++) run_len[i] = 0;
            m_warn = 0; m_age = 0; m_evt = 0; m_pend = 1'b0;
            model_ok = 1'b1;
        end else if (model_ok) begin
            if (!m_pend) begin
                if (cand != 0) begin
                    m_pend = 1'b1; m_warn = cand; m_age = 0;
                    m_evt = (m_evt < EVMAX) ? m_evt + 1 : m_evt;
                end
            end else if (cand > m_warn) begin
                m_warn = cand; m_age = 0;
                m_evt = (m_evt < EVMAX) ? m_evt + 1 : m_evt;
            end else if (m_age < HOLD - 1) begin
                m_age++;
            end else if (bus.ack) begin
                if (cand == 0) begin
                    m_pend = 1'b0; m_warn = 0;
                end else begin
                    m_warn = cand; m_age = 0;
                end
            end
            for (int i = 0; i < NS; i++) run_len[i] = bus.abnormality[i] ? run_len[i] + 1 : 0;
        end
    end

    always @(negedge clock) begin
        if (model_ok) begin
            check("model_warning", int'(bus.abnormalityWarning), m_warn);
            check("model_pending", int'(bus.alarmPending), int'(m_pend));
            check("model_events", int'(bus.eventCount), m_evt);
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic lit(input int warn, input int pend, input int evt, input string tag);
        check({tag, "_warning"}, int'(bus.abnormalityWarning), warn);
        check({tag, "_pending"}, int'(bus.alarmPending), pend);
        if (evt >= 0) check({tag, "_events"}, int'(bus.eventCount), evt);
    endtask

    initial begin
        reset = 1'b1;
        bus.abnormality = '0;
        bus.ack = 1'b0;
        cycles(2);
        reset = 1'b0;
        lit(0, 0, 0, "reset");

        // Two-cycle glitch never confirms.
        bus.abnormality = 6'b000100; cycles(2);
        bus.abnormality = '0;        cycles(3);
        lit(0, 0, 0, "glitch");

        // Confirmation on the 4th edge, then sticky after the line drops.
        bus.abnormality = 6'b000010; cycles(3);
        lit(0, 0, 0, "confirm_early");
        cycles(1);
        lit(2, 1, 1, "confirm");
        bus.abnormality = '0; cycles(20);
        lit(2, 1, 1, "sticky");

        // Higher source pre-empts; lower confirmed source does not replace it.
        bus.abnormality = 6'b100000; cycles(3);
        lit(2, 1, 1, "preempt_early");
        cycles(1);
        lit(6, 1, 2, "preempt");
        bus.abnormality = 6'b001000; cycles(1);
        bus.ack = 1'b1; cycles(1); bus.ack = 1'b0;
        lit(6, 1, 2, "ack_in_hold");
        cycles(12);
        lit(6, 1, 2, "lower_no_replace");
        bus.ack = 1'b1; cycles(1); bus.ack = 1'b0;
        lit(4, 1, 2, "ack_lower");
        bus.abnormality = '0; cycles(10);
        bus.ack = 1'b1; cycles(1); bus.ack = 1'b0;
        lit(0, 0, 2, "ack_clear");
        bus.ack = 1'b1; cycles(2); bus.ack = 1'b0;
        lit(0, 0, 2, "ack_idle");

        // Ack on the same edge as a pre-emption: pre-emption wins and reloads hold.
        bus.abnormality = 6'b000001; cycles(4);
        lit(1, 1, 3, "low_alarm");
        cycles(10);
        bus.abnormality = 6'b010001; cycles(3);
        bus.ack = 1'b1; cycles(1);
        lit(5, 1, 4, "simul_preempt");
        cycles(1); bus.ack = 1'b0;
        lit(5, 1, 4, "simul_hold_reload");

        // Reset mid-alarm discards partial and full confirm counts.
        bus.abnormality = 6'b110001; cycles(4);
        lit(6, 1, 5, "pre_reset");
        reset = 1'b1; cycles(1); reset = 1'b0;
        lit(0, 0, 0, "mid_reset");
        cycles(3);
        lit(0, 0, 0, "reconfirm_early");
        cycles(1);
        lit(6, 1, 1, "reconfirm");

        // Drive enough alarm/clear rounds to pin the event counter at its ceiling.
        bus.abnormality = '0; cycles(10);
        bus.ack = 1'b1; cycles(1); bus.ack = 1'b0;
        lit(0, 0, 1, "pre_saturate");
        for (int k = 0; k < 260; k++) begin
            bus.abnormality = 6'b000001; cycles(4);
            bus.abnormality = '0;        cycles(8);
            bus.ack = 1'b1; cycles(1); bus.ack = 1'b0;
        end
        lit(0, 0, EVMAX, "saturate");
        bus.abnormality = 6'b000001; cycles(4);
        lit(1, 1, EVMAX, "no_wrap");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
